// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: the instruction-class enum, major
// opcode constants and small helpers that say which register fields a
// class reads and whether it produces a register result.
package riscv_pkg;

  typedef enum logic [3:0] {
    R       = 4'd0,
    I_ALU   = 4'd1,
    LOAD    = 4'd2,
    STORE   = 4'd3,
    BRANCH  = 4'd4,
    JAL     = 4'd5,
    JALR    = 4'd6,
    LUI     = 4'd7,
    AUIPC   = 4'd8,
    SYSTEM  = 4'd9,
    ILLEGAL = 4'd10
  } instr_type_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Classes that produce a value in rd and therefore reserve it.
  function automatic logic writes_rd(input instr_type_t t);
    return (t == R) || (t == I_ALU) || (t == LOAD) || (t == JAL) ||
           (t == JALR) || (t == LUI) || (t == AUIPC);
  endfunction

  function automatic logic uses_rs1(input instr_type_t t);
    return !((t == LUI) || (t == AUIPC) || (t == JAL));
  endfunction

  function automatic logic uses_rs2(input instr_type_t t);
    return (t == R) || (t == STORE) || (t == BRANCH);
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational opcode classification and immediate formation.
// Ports:
//   instr_i   - raw RV32I instruction word
//   type_o    - instruction class
//   imm_o     - immediate, sign-extended (U-type is upper-20 with zero low bits)
//   illegal_o - opcode is not one of the supported major opcodes
module rv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_type_t  type_o,
  output logic [31:0]  imm_o,
  output logic         illegal_o
);

  logic [31:0] imm_i_fmt;
  logic [31:0] imm_s_fmt;
  logic [31:0] imm_b_fmt;
  logic [31:0] imm_u_fmt;
  logic [31:0] imm_j_fmt;

  assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_fmt = {instr_i[31:12], 12'b0};
  assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    type_o    = ILLEGAL;
    imm_o     = 32'd0;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPC_OP:       type_o = R;
      // Shift-immediates keep the full I immediate; execute looks at
      // imm[4:0] and instruction bit 30 itself.
      OPC_OP_IMM:   begin type_o = I_ALU;  imm_o = imm_i_fmt; end
      OPC_LOAD:     begin type_o = LOAD;   imm_o = imm_i_fmt; end
      OPC_STORE:    begin type_o = STORE;  imm_o = imm_s_fmt; end
      OPC_BRANCH:   begin type_o = BRANCH; imm_o = imm_b_fmt; end
      OPC_JAL:      begin type_o = JAL;    imm_o = imm_j_fmt; end
      OPC_JALR:     begin type_o = JALR;   imm_o = imm_i_fmt; end
      OPC_LUI:      begin type_o = LUI;    imm_o = imm_u_fmt; end
      OPC_AUIPC:    begin type_o = AUIPC;  imm_o = imm_u_fmt; end
      OPC_SYSTEM,
      OPC_MISC_MEM: type_o = SYSTEM;
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_decode_issue.sv
// RV32I decode/issue stage: decodes the offered instruction, reads the
// register file (with writeback bypass), checks the pending scoreboard for
// RAW hazards and registers a one-entry issue bundle.
//
// Handshake: a transfer happens on a channel in any cycle where both valid
// and ready are high at the rising edge. Valid never depends on ready; once
// iss_valid is high the bundle is held unchanged until iss_ready is seen.
//
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   instr_valid/instr_ready     - fetch side handshake, instr = raw word
//   iss_valid/iss_ready         - execute side handshake
//   iss_idata, iss_rv1, iss_rv2 - instruction copy and operand values
//   iss_imm, iss_rd, iss_type   - immediate, destination, class
//   iss_illegal                 - unsupported opcode flag
//   wb_en, wb_rd, wb_data       - register writeback from execute
module rv_decode_issue
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_idata,
  output logic [31:0] iss_rv1,
  output logic [31:0] iss_rv2,
  output logic [31:0] iss_imm,
  output logic [4:0]  iss_rd,
  output instr_type_t iss_type,
  output logic        iss_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  instr_type_t dec_type;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  rv_imm_gen u_imm_gen (
    .instr_i   (instr),
    .type_o    (dec_type),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  logic [4:0]  rs1, rs2, rd;
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  logic [31:0] rf_q [32];
  logic [31:0] pending_q, pending_d;

  logic        iss_valid_q;
  logic [31:0] iss_idata_q, iss_rv1_q, iss_rv2_q, iss_imm_q;
  logic [4:0]  iss_rd_q;
  instr_type_t iss_type_q;
  logic        iss_illegal_q;

  // Register read with same-cycle writeback bypass; x0 is hardwired to 0.
  logic [31:0] rv1, rv2;
  always_comb begin
    rv1 = 32'd0;
    rv2 = 32'd0;
    if (rs1 != 5'd0) rv1 = (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rv2 = (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  // A pending source that is being written back this cycle is already
  // satisfied through the bypass, so it does not stall.
  logic hz1, hz2, hazard;
  assign hz1    = uses_rs1(dec_type) && pending_q[rs1] && !(wb_en && wb_rd == rs1);
  assign hz2    = uses_rs2(dec_type) && pending_q[rs2] && !(wb_en && wb_rd == rs2);
  assign hazard = hz1 || hz2;

  logic accept;
  assign instr_ready = (!iss_valid_q || iss_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Clear first, then set, so a new reservation wins over a writeback
  // of the same register in the same cycle.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_rd] = 1'b0;
    if (accept && writes_rd(dec_type) && rd != 5'd0) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q   <= 1'b0;
      iss_idata_q   <= 32'd0;
      iss_rv1_q     <= 32'd0;
      iss_rv2_q     <= 32'd0;
      iss_imm_q     <= 32'd0;
      iss_rd_q      <= 5'd0;
      iss_type_q    <= R;
      iss_illegal_q <= 1'b0;
    end else if (accept) begin
      iss_valid_q   <= 1'b1;
      iss_idata_q   <= instr;
      iss_rv1_q     <= rv1;
      iss_rv2_q     <= rv2;
      iss_imm_q     <= dec_imm;
      iss_rd_q      <= rd;
      iss_type_q    <= dec_type;
      iss_illegal_q <= dec_illegal;
    end else if (iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_idata   = iss_idata_q;
  assign iss_rv1     = iss_rv1_q;
  assign iss_rv2     = iss_rv2_q;
  assign iss_imm     = iss_imm_q;
  assign iss_rd      = iss_rd_q;
  assign iss_type    = iss_type_q;
  assign iss_illegal = iss_illegal_q;

endmodule

// File: tb/tb_rv_decode_issue.sv
module tb_rv_decode_issue;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_idata, iss_rv1, iss_rv2, iss_imm;
  logic [4:0]  iss_rd;
  instr_type_t iss_type;
  logic        iss_illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv_decode_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_idata   (iss_idata),
    .iss_rv1     (iss_rv1),
    .iss_rv2     (iss_rv2),
    .iss_imm     (iss_imm),
    .iss_rd      (iss_rd),
    .iss_type    (iss_type),
    .iss_illegal (iss_illegal),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction and let combinational outputs settle.
  task automatic offer(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; iss_ready = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #1;
    chk("rst_valid",   32'(iss_valid), 32'd0);
    chk("rst_illegal", 32'(iss_illegal), 32'd0);
    chk("rst_type",    32'(iss_type), 32'(R));
    chk("rst_imm",     iss_imm, 32'd0);
    chk("rst_rd",      32'(iss_rd), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // ADDI x1,x0,-5
    offer(32'hFFB00093);
    chk("addi1_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("addi1_valid", 32'(iss_valid), 32'd1);
    chk("addi1_imm",   iss_imm, 32'hFFFFFFFB);
    chk("addi1_rd",    32'(iss_rd), 32'd1);
    chk("addi1_rv1",   iss_rv1, 32'd0);
    chk("addi1_type",  32'(iss_type), 32'(I_ALU));

    // Stall on execute for 3 cycles with ADDI x2,x1,1 offered.
    offer(32'h00108113);
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", 32'(instr_ready), 32'd0);
      tick();
      chk("hold_valid", 32'(iss_valid), 32'd1);
      chk("hold_idata", iss_idata, 32'hFFB00093);
      chk("hold_imm",   iss_imm, 32'hFFFFFFFB);
      chk("hold_rd",    32'(iss_rd), 32'd1);
    end

    // Execute consumes; x1 still pending so ADDI x2 stalls.
    iss_ready = 1'b1;
    #1;
    chk("raw_ready_a", 32'(instr_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(iss_valid), 32'd0);
    chk("raw_ready_b", 32'(instr_ready), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
    #1;
    chk("wb_ready", 32'(instr_ready), 32'd1);
    tick();
    wb_en = 1'b0; instr_valid = 1'b0;
    chk("addi2_valid", 32'(iss_valid), 32'd1);
    chk("addi2_rv1",   iss_rv1, 32'd7);
    chk("addi2_rd",    32'(iss_rd), 32'd2);
    chk("addi2_imm",   iss_imm, 32'd1);
    tick();
    chk("addi2_drain", 32'(iss_valid), 32'd0);

    // Retire x2 = 0x11, then attempt a write to x0.
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h11;
    tick();
    wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
    // ADD x3,x0,x2
    offer(32'h002001B3);
    chk("add_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("add_rv1",  iss_rv1, 32'd0);
    chk("add_rv2",  iss_rv2, 32'h11);
    chk("add_type", 32'(iss_type), 32'(R));
    chk("add_imm",  iss_imm, 32'd0);

    // Illegal opcodes, second one with rd=x4 which must not be reserved.
    offer(32'h0000007F);
    chk("ill_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("ill_flag", 32'(iss_illegal), 32'd1);
    chk("ill_type", 32'(iss_type), 32'(ILLEGAL));
    offer(32'h0000027F);
    tick();
    chk("ill2_flag", 32'(iss_illegal), 32'd1);
    chk("ill2_imm",  iss_imm, 32'd0);
    // ADDI x5,x4,0 must not stall.
    offer(32'h00020293);
    chk("ill_noreserve", 32'(instr_ready), 32'd1);
    tick();
    chk("addi5_illegal", 32'(iss_illegal), 32'd0);
    chk("addi5_rd",      32'(iss_rd), 32'd5);

    // Immediate formats.
    offer(32'h12345337); // LUI x6,0x12345
    tick();
    chk("lui_imm",  iss_imm, 32'h12345000);
    chk("lui_type", 32'(iss_type), 32'(LUI));
    offer(32'hFE202E23); // SW x2,-4(x0)
    tick();
    chk("sw_imm",  iss_imm, 32'hFFFFFFFC);
    chk("sw_type", 32'(iss_type), 32'(STORE));
    chk("sw_rv2",  iss_rv2, 32'h11);
    offer(32'hFE000CE3); // BEQ x0,x0,-8
    tick();
    chk("beq_imm",  iss_imm, 32'hFFFFFFF8);
    chk("beq_type", 32'(iss_type), 32'(BRANCH));

    // JAL x1,+2048 accepted while x1 is written back: reservation wins.
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    offer(32'h001000EF);
    chk("jal_ready", 32'(instr_ready), 32'd1);
    tick();
    wb_en = 1'b0;
    chk("jal_imm",  iss_imm, 32'h00000800);
    chk("jal_type", 32'(iss_type), 32'(JAL));
    chk("jal_rd",   32'(iss_rd), 32'd1);
    offer(32'h00108113);
    chk("setwins_ready", 32'(instr_ready), 32'd0);

    // Reset mid-operation with a held bundle and x1 pending.
    iss_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(iss_valid), 32'd0);
    chk("midrst_imm",   iss_imm, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    iss_ready = 1'b1;
    #1;
    chk("postrst_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("postrst_valid", 32'(iss_valid), 32'd1);
    chk("postrst_rv1",   iss_rv1, 32'd0);
    chk("postrst_rd",    32'(iss_rd), 32'd2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
